// File: rtl/vga_pkg.sv
// Shared constants and the VGA timing bundle type for the sync-delay pipeline.
package vga_pkg;

    localparam int CNT_W_DEF  = 11;
    localparam int DATA_W_DEF = 12;

    localparam logic SYNC_IDLE = 1'b0;
    localparam logic BLNK_IDLE = 1'b1;

    typedef struct packed {
        logic                  hsync;
        logic                  vsync;
        logic                  hblnk;
        logic                  vblnk;
        logic [CNT_W_DEF-1:0]  hcount;
        logic [CNT_W_DEF-1:0]  vcount;
        logic [DATA_W_DEF-1:0] rgb;
    } vga_bundle_t;

    // Flattened width of the bundle for arbitrary count/colour widths.
    function automatic int bundle_width(input int cnt_w, input int data_w);
        return 4 + 2 * cnt_w + data_w;
    endfunction

endpackage

// File: rtl/delay_tap_line.sv
// Generic DEPTH x W shift chain with synchronous reset value and a
// combinational tap select (tap 0 is the live input, tap k is stage k-1).
module delay_tap_line #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [W-1:0]     i_rst_val,
    input  logic [W-1:0]     i_d,
    input  logic [SEL_W-1:0] i_sel,
    output logic [W-1:0]     o_tap
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= i_rst_val;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // Selects beyond the chain fall back to the live input rather than indexing out of range.
    always_comb begin
        o_tap = i_d;
        for (int k = 1; k <= DEPTH; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_tap = r_stage[k-1];
            end
        end
    end

endmodule

// File: rtl/vga_sync_delay.sv
// Run-time selectable delay for the VGA timing bundle and pixel data; the delay
// only changes on a vsync_in rising edge. Optional VGA_DELAY_FRAME_CNT_EN adds frame_cnt.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int MAX_DELAY = 4,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SEL_W     = $clog2(MAX_DELAY + 1)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  delay_sel,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [CNT_W-1:0]  hcount_in,
    input  logic [CNT_W-1:0]  vcount_in,
    input  logic [DATA_W-1:0] rgb_in,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [CNT_W-1:0]  hcount_out,
    output logic [CNT_W-1:0]  vcount_out,
    output logic [DATA_W-1:0] rgb_out,
    output logic [SEL_W-1:0]  delay_active,
`ifdef VGA_DELAY_FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic              primed
);

    localparam int BW     = bundle_width(CNT_W, DATA_W);
    localparam int FILL_W = $clog2(MAX_DELAY + 2);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_DELAY + 1);
    localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(MAX_DELAY);

    logic [BW-1:0]     w_bundle_in;
    logic [BW-1:0]     w_idle;
    logic [BW-1:0]     w_tap;
    logic [SEL_W-1:0]  w_req;
    logic [SEL_W-1:0]  w_delay_next;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_frame_edge;

    logic [BW-1:0]     r_out;
    logic [SEL_W-1:0]  r_delay_active;
    logic [FILL_W-1:0] r_fill;
    logic              r_vsync_prev;
    logic              r_primed;

    assign w_bundle_in = {hsync_in, vsync_in, hblnk_in, vblnk_in, hcount_in, vcount_in, rgb_in};
    assign w_idle      = {SYNC_IDLE, SYNC_IDLE, BLNK_IDLE, BLNK_IDLE,
                          {CNT_W{1'b0}}, {CNT_W{1'b0}}, {DATA_W{1'b0}}};

    assign w_req        = (delay_sel > SEL_MAX) ? SEL_MAX : delay_sel;
    assign w_frame_edge = vsync_in & ~r_vsync_prev;
    assign w_delay_next = w_frame_edge ? w_req : r_delay_active;
    assign w_fill_next  = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);

    delay_tap_line #(
        .DEPTH (MAX_DELAY),
        .W     (BW),
        .SEL_W (SEL_W)
    ) u_taps (
        .i_clk     (pclk),
        .i_rst     (rst),
        .i_rst_val (w_idle),
        .i_d       (w_bundle_in),
        .i_sel     (r_delay_active),
        .o_tap     (w_tap)
    );

    // primed uses the post-edge fill and delay so it rises on the same edge as the first valid output.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_out          <= w_idle;
            r_delay_active <= '0;
            r_fill         <= '0;
            r_vsync_prev   <= 1'b0;
            r_primed       <= 1'b0;
        end else begin
            r_out          <= w_tap;
            r_delay_active <= w_delay_next;
            r_fill         <= w_fill_next;
            r_vsync_prev   <= vsync_in;
            r_primed       <= (int'(w_fill_next) >= int'(w_delay_next) + 1);
        end
    end

    assign {hsync_out, vsync_out, hblnk_out, vblnk_out, hcount_out, vcount_out, rgb_out} = r_out;
    assign delay_active = r_delay_active;
    assign primed       = r_primed;

`ifdef VGA_DELAY_FRAME_CNT_EN
    logic        r_vsync_out_prev;
    logic [15:0] r_frame_cnt;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vsync_out_prev <= 1'b0;
            r_frame_cnt      <= 16'd0;
        end else begin
            r_vsync_out_prev <= vsync_out;
            if (vsync_out && !r_vsync_out_prev) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
